mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the 5-stage pipeline.
- Grants one access at a time, sequences read latency and returns read data to the owner.
- Drives per-requester stall so each stage holds its request stable until it completes.
- DM has fixed priority (older instruction); IF is protected by an optional starvation guard.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the IF and DM pipeline stages.
// Define ARB_STARVE_GUARD_EN to let a pending IF request win after STARVE_LIMIT consecutive DM grants.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  output logic                    if_stall,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_valid,
  output logic                    dm_stall,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CNT_WIDTH = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t               state, state_next;
  owner_t               owner, owner_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;

  logic done, if_done, dm_done, port_free;
  logic if_pend, dm_pend, force_if;
  logic grant_if, grant_dm, dm_write;

  // The completing owner is excluded from the grant so its finished request is never reissued.
  assign done      = rstn && (state == BUSY) && (cnt == '0);
  assign if_done   = done && (owner == OWN_IF);
  assign dm_done   = done && (owner == OWN_DM);
  assign port_free = rstn && ((state == IDLE) || done);
  assign if_pend   = port_free && if_req && !if_done;
  assign dm_pend   = port_free && dm_req && !dm_done;
  assign grant_dm  = dm_pend && !force_if;
  assign grant_if  = if_pend && !grant_dm;
  assign dm_write  = grant_dm && dm_we;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SCNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCNT_WIDTH-1:0] SCNT_MAX = SCNT_WIDTH'(STARVE_LIMIT);

  logic [SCNT_WIDTH-1:0] scnt;

  assign force_if = (scnt == SCNT_MAX) && if_pend && dm_pend;

  // Counts DM grants taken while IF was waiting; saturates at the limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scnt <= '0;
    end else if (grant_if) begin
      scnt <= '0;
    end else if (grant_dm && if_req && !if_done && (scnt != SCNT_MAX)) begin
      scnt <= scnt + SCNT_WIDTH'(1);
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      owner <= OWN_IF;
      cnt   <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    cnt_next   = cnt;
    mem_en     = grant_if || grant_dm;
    mem_we     = dm_write;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    if_valid   = if_done;
    if_rdata   = '0;
    dm_valid   = dm_done || dm_write;
    dm_rdata   = '0;
    if_stall   = 1'b0;
    dm_stall   = 1'b0;

    if (state == BUSY) begin
      if (cnt == '0) begin
        state_next = IDLE;
      end else begin
        cnt_next = cnt - CNT_WIDTH'(1);
      end
    end

    // A new read overrides the completion return to IDLE, giving zero-bubble handover.
    if (grant_if || (grant_dm && !dm_we)) begin
      state_next = BUSY;
      owner_next = grant_dm ? OWN_DM : OWN_IF;
      cnt_next   = CNT_LOAD;
    end

    if (grant_dm) begin
      mem_addr = dm_addr;
      if (dm_we) begin
        mem_wdata = dm_wdata;
        mem_be    = dm_be;
      end else begin
        mem_be = '1;
      end
    end else if (grant_if) begin
      mem_addr = if_addr;
      mem_be   = '1;
    end

    if (if_done) begin
      if_rdata = mem_rdata;
    end
    if (dm_done) begin
      dm_rdata = mem_rdata;
    end

    if_stall = rstn && if_req && !if_valid;
    dm_stall = rstn && dm_req && !dm_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; expectations for the starvation scenario follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid, if_stall;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [BW-1:0] dm_be = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid, dm_stall;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata)
  );

  typedef struct {int cyc; logic we; logic [AW-1:0] addr; logic [BW-1:0] be; logic [DW-1:0] wdata;} issue_t;
  typedef struct {int cyc; logic [DW-1:0] data; bit chk;} resp_t;
  typedef struct {int due; logic [DW-1:0] data;} rd_t;

  issue_t        issue_q[$];
  resp_t         if_q[$];
  resp_t         dm_q[$];
  rd_t           rd_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t, wr_idx;
  bit if_seen;

  issue_t        mon_issue;
  resp_t         mon_resp;
  rd_t           mon_rd;
  logic [DW-1:0] mon_word;

  function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Memory model: read data appears LAT cycles after issue, garbage otherwise.
  always @(posedge clk) begin
    cyc = cyc + 1;
    mem_rdata = 32'hBAD0_0BAD;
    while (rd_q.size() > 0 && rd_q[0].due < cyc) rd_q.delete(0);
    if (rd_q.size() > 0 && rd_q[0].due == cyc) mem_rdata = rd_q[0].data;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (mem_en) begin
        if (mem_we) begin
          mon_word = memRead(mem_addr);
          for (int b = 0; b < BW; b++) if (mem_be[b]) mon_word[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = mon_word;
        end else begin
          mon_rd.due = cyc + LAT;
          mon_rd.data = memRead(mem_addr);
          rd_q.push_back(mon_rd);
        end
        checks++;
        if (issue_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL mem_issue: unexpected access cycle=%0d we=%b addr=%h, required none", cyc, mem_we, mem_addr);
        end else begin
          mon_issue = issue_q.pop_front();
          if (mon_issue.cyc != cyc || mon_issue.we !== mem_we || mon_issue.addr !== mem_addr ||
              mon_issue.be !== mem_be || (mon_issue.we && mon_issue.wdata !== mem_wdata)) begin
            errors++;
            $display("[TB] FAIL mem_issue: got cyc=%0d we=%b addr=%h be=%h wdata=%h, required cyc=%0d we=%b addr=%h be=%h wdata=%h",
                     cyc, mem_we, mem_addr, mem_be, mem_wdata,
                     mon_issue.cyc, mon_issue.we, mon_issue.addr, mon_issue.be, mon_issue.wdata);
          end
        end
      end else begin
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || mem_be !== '0) begin
          errors++;
          $display("[TB] FAIL mem_idle: cycle=%0d we=%b addr=%h wdata=%h be=%h, required all 0", cyc, mem_we, mem_addr, mem_wdata, mem_be);
        end
      end

      checks++;
      if (if_valid) begin
        if (if_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL if_resp: unexpected if_valid cycle=%0d, required none", cyc);
        end else begin
          mon_resp = if_q.pop_front();
          if (mon_resp.cyc != cyc || if_rdata !== mon_resp.data) begin
            errors++;
            $display("[TB] FAIL if_resp: got cyc=%0d data=%h, required cyc=%0d data=%h", cyc, if_rdata, mon_resp.cyc, mon_resp.data);
          end
        end
      end else if (if_rdata !== '0) begin
        errors++;
        $display("[TB] FAIL if_rdata_idle: got %h, required 0", if_rdata);
      end

      checks++;
      if (dm_valid) begin
        if (dm_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL dm_resp: unexpected dm_valid cycle=%0d, required none", cyc);
        end else begin
          mon_resp = dm_q.pop_front();
          if (mon_resp.cyc != cyc || (mon_resp.chk && dm_rdata !== mon_resp.data)) begin
            errors++;
            $display("[TB] FAIL dm_resp: got cyc=%0d data=%h, required cyc=%0d data=%h", cyc, dm_rdata, mon_resp.cyc, mon_resp.data);
          end
        end
      end else if (dm_rdata !== '0) begin
        errors++;
        $display("[TB] FAIL dm_rdata_idle: got %h, required 0", dm_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr, input logic dreq, input logic dwe,
                               input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata, input logic [BW-1:0] dbe);
    if_req   = ireq;
    if_addr  = iaddr;
    dm_req   = dreq;
    dm_we    = dwe;
    dm_addr  = daddr;
    dm_wdata = dwdata;
    dm_be    = dbe;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expIssue(input int c, input logic we, input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] wd);
    issue_t e;
    e.cyc = c; e.we = we; e.addr = a; e.be = be; e.wdata = wd;
    issue_q.push_back(e);
  endtask

  task automatic expResp(input bit is_dm, input int c, input logic [DW-1:0] d, input bit chk);
    resp_t r;
    r.cyc = c; r.data = d; r.chk = chk;
    if (is_dm) dm_q.push_back(r);
    else if_q.push_back(r);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_ctrl"}, 32'({mem_en, mem_we, if_stall, dm_stall, if_valid, dm_valid}), 32'h0);
    checkOutput({name, "_addr"}, mem_addr, 32'h0);
    checkOutput({name, "_wdata"}, mem_wdata, 32'h0);
    checkOutput({name, "_be"}, 32'(mem_be), 32'h0);
    checkOutput({name, "_if_rdata"}, if_rdata, 32'h0);
    checkOutput({name, "_dm_rdata"}, dm_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem[32'h40] = 32'h00A0_0093;
    mem[32'h44] = 32'h1234_5678;
    mem[32'h48] = 32'hCAFE_F00D;
    mem[32'h4C] = 32'h0BAD_F00D;
    mem[32'h10] = 32'h1122_3344;

    // Outputs must stay quiet under reset even with both requests raised.
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checkResetOutputs("init_reset");
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rstn = 1'b1;
    step();

    // IF read alone.
    step(); t = cyc;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expIssue(t, 1'b0, 32'h40, 4'hF, 32'h0);
    expResp(1'b0, t + 2, 32'h00A0_0093, 1'b1);
    @(negedge clk); checkOutput("t1_if_stall_T", 32'(if_stall), 32'h1);
    step(); @(negedge clk); checkOutput("t1_if_stall_T1", 32'(if_stall), 32'h1);
    step(); @(negedge clk); checkOutput("t1_if_stall_T2", 32'(if_stall), 32'h0);
    step(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();

    // DM write and IF read in the same cycle.
    step(); t = cyc;
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    expIssue(t, 1'b1, 32'h10, 4'b0011, 32'hDEAD_BEEF);
    expResp(1'b1, t, 32'h0, 1'b0);
    expIssue(t + 1, 1'b0, 32'h44, 4'hF, 32'h0);
    expResp(1'b0, t + 3, 32'h1234_5678, 1'b1);
    @(negedge clk);
    checkOutput("t2_if_stall_T", 32'(if_stall), 32'h1);
    checkOutput("t2_dm_stall_T", 32'(dm_stall), 32'h0);
    step(); applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t2_if_stall_T1", 32'(if_stall), 32'h1);
    step(); step(); step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();

    // DM read arriving while an IF read is in flight; also reads back the byte-masked write.
    step(); t = cyc;
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expIssue(t, 1'b0, 32'h48, 4'hF, 32'h0);
    expResp(1'b0, t + 2, 32'hCAFE_F00D, 1'b1);
    expIssue(t + 2, 1'b0, 32'h10, 4'hF, 32'h0);
    expResp(1'b1, t + 4, 32'h1122_BEEF, 1'b1);
    step(); applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t3_dm_stall_T1", 32'(dm_stall), 32'h1);
    step(); @(negedge clk);
    checkOutput("t3_dm_stall_T2", 32'(dm_stall), 32'h1);
    checkOutput("t3_if_stall_T2", 32'(if_stall), 32'h0);
    step(); applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t3_dm_stall_T3", 32'(dm_stall), 32'h1);
    step(); @(negedge clk); checkOutput("t3_dm_stall_T4", 32'(dm_stall), 32'h0);
    step(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();

    // Reset in the middle of an IF read abandons it.
    step(); t = cyc;
    applyStimulus(1'b1, 32'h4C, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    expIssue(t, 1'b0, 32'h4C, 4'hF, 32'h0);
    step();
    rstn = 1'b0;
    applyStimulus(1'b1, 32'h4C, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk); checkResetOutputs("t4_reset");
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); checkOutput("t4_no_valid_after_release", 32'(if_valid), 32'h0);
      step();
    end

    // DM write stream with IF pending: starvation guard behaviour.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step(); t = cyc;
    wr_idx = 0;
    if_seen = 1'b0;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 32'hA000_0000, 4'hF);
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) begin
      expIssue(t + k, 1'b1, 32'h80 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k));
      expResp(1'b1, t + k, 32'h0, 1'b0);
    end
    expIssue(t + 4, 1'b0, 32'h40, 4'hF, 32'h0);
    expIssue(t + 6, 1'b1, 32'h90, 4'hF, 32'hA000_0004);
    expResp(1'b1, t + 6, 32'h0, 1'b0);
    expResp(1'b0, t + 6, 32'h00A0_0093, 1'b1);
`else
    for (int k = 0; k < 5; k++) begin
      expIssue(t + k, 1'b1, 32'h80 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k));
      expResp(1'b1, t + k, 32'h0, 1'b0);
    end
    expIssue(t + 5, 1'b0, 32'h40, 4'hF, 32'h0);
    expResp(1'b0, t + 7, 32'h00A0_0093, 1'b1);
`endif
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dm_valid && dm_req) wr_idx++;
      if (if_valid) if_seen = 1'b1;
      if (wr_idx == 5 && if_seen) break;
      step();
      applyStimulus(!if_seen, 32'h40, wr_idx < 5, 1'b1, 32'h80 + 32'(4 * wr_idx),
                    32'hA000_0000 + 32'(wr_idx), 4'hF);
    end
    checkOutput("t5_stream_complete", {30'h0, wr_idx == 5, if_seen}, 32'h3);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    repeat (4) step();
    checkOutput("left_issue", 32'(issue_q.size()), 32'h0);
    checkOutput("left_if_resp", 32'(if_q.size()), 32'h0);
    checkOutput("left_dm_resp", 32'(dm_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
